// File: rtl/clk_en_sched_pkg.sv
// clk_en_sched_pkg
// Shared definitions for the run-time clock-enable scheduler:
//   - FSM state encoding (IDLE = 0, RUN = 1)
//   - default widths for the divisor/period counter and the burst/pulse counter
package clk_en_sched_pkg;

  // Default divisor / period counter width.
  localparam int DEF_CNT_W   = 6;
  // Default burst length / pulse counter width.
  localparam int DEF_BURST_W = 8;

  // FSM state encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/clk_en_period_cnt.sv
// clk_en_period_cnt
// Period counter for the clock-enable scheduler. Counts 0..div_i while enabled
// and flags the wrap; the registered enable pulse follows one cycle after the
// wrap, so pulses are spaced div_i+1 cycles apart.
//
// Ports:
//   clk_i     in   clock, rising edge
//   rst_i     in   asynchronous active-high reset
//   clear_i   in   synchronous clear of counter and pulse (takes priority)
//   enable_i  in   count this cycle
//   div_i     in   divisor; the counter wraps when it equals div_i
//   wrap_o    out  combinational: the counter wraps on the coming edge
//   clk_en_o  out  registered enable pulse, high for the cycle after a wrap
module clk_en_period_cnt
  import clk_en_sched_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             wrap_o,
  output logic             clk_en_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_clk_en;

  // A clear suppresses the wrap so an aborted run never emits a late pulse.
  assign wrap_o   = enable_i && !clear_i && (r_cnt == div_i);
  assign clk_en_o = r_clk_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
    end else if (clear_i) begin
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
    end else if (enable_i) begin
      if (r_cnt == div_i) begin
        r_cnt    <= '0;
        r_clk_en <= 1'b1;
      end else begin
        r_cnt    <= r_cnt + CNT_W'(1);
        r_clk_en <= 1'b0;
      end
    end else begin
      r_clk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_sched.sv
// clk_en_sched
// Run-time clock-enable scheduler. A divisor and burst length are loaded over
// a valid/ready config port while idle; start_i then launches a run that emits
// single-cycle clk_en_o pulses every DIV+1 cycles, ending after BURST pulses
// (with done_o on the last one) or running until stop_i when BURST is 0.
//
// Optional feature macro: CLK_EN_SCHED_GRACEFUL_STOP_EN
//   defined   : stop_i in RUN lets the current period finish; the final pulse
//               carries done_o, then the block returns to IDLE.
//   undefined : stop_i in RUN aborts at once (no pulse, no done_o).
//
// Config handshake: a transfer happens on a rising edge where cfg_valid_i and
// cfg_ready_o are both high; cfg_ready_o is high exactly while IDLE, and the
// offer may be withdrawn or changed freely while not accepted.
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   asynchronous active-high reset
//   cfg_valid_i  in   config offer
//   cfg_ready_o  out  config accepted when high together with cfg_valid_i
//   cfg_div_i    in   divisor DIV (period = DIV+1 cycles)
//   cfg_burst_i  in   pulse count, 0 = continuous
//   start_i      in   begin a run (level-sampled)
//   stop_i       in   abort / end a run
//   clk_en_o     out  registered enable pulse
//   busy_o       out  high while in RUN
//   done_o       out  one-cycle pulse with the final clk_en_o of a run
//   dbg_state_o  out  current FSM state (debug visibility)
module clk_en_sched
  import clk_en_sched_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [CNT_W-1:0]   cfg_div_i,
  input  logic [BURST_W-1:0] cfg_burst_i,
  input  logic               start_i,
  input  logic               stop_i,
  output logic               clk_en_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [0:0]         dbg_state_o
);

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_div_q;
  logic [BURST_W-1:0] r_burst_q;
  logic [BURST_W-1:0] r_pulse_cnt;
  logic               r_done;

  logic               w_idle;
  logic               w_run;
  logic               w_cfg_hs;
  logic               w_start;
  logic               w_abort;
  logic               w_clear;
  logic               w_wrap;
  logic [BURST_W-1:0] w_pulse_nxt;
  logic               w_last;
  logic               w_end;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_run    = (r_state == ST_RUN);
  assign w_cfg_hs = cfg_valid_i && w_idle;
  // Stop wins over a simultaneous start.
  assign w_start  = w_idle && start_i && !stop_i;

  // Pulse counter never exceeds burst_q-1 in burst mode, so the +1 cannot
  // overflow there; in continuous mode it saturates below.
  assign w_pulse_nxt = r_pulse_cnt + BURST_W'(1);
  assign w_last      = (r_burst_q != '0) && (w_pulse_nxt == r_burst_q);

`ifdef CLK_EN_SCHED_GRACEFUL_STOP_EN
  logic r_stop_pend;

  assign w_abort = 1'b0;
  // A stop seen on the wrap edge itself ends the run at that wrap.
  assign w_end   = w_wrap && (w_last || stop_i || r_stop_pend);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stop_pend <= 1'b0;
    end else if (w_idle || w_end) begin
      r_stop_pend <= 1'b0;
    end else if (stop_i) begin
      r_stop_pend <= 1'b1;
    end
  end
`else
  assign w_abort = w_run && stop_i;
  assign w_end   = w_wrap && w_last;
`endif

  // Counter restarts on every new run and on an abort.
  assign w_clear = w_start || w_abort;

  clk_en_period_cnt #(
    .CNT_W (CNT_W)
  ) u_period_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (w_clear),
    .enable_i (w_run),
    .div_i    (r_div_q),
    .wrap_o   (w_wrap),
    .clk_en_o (clk_en_o)
  );

  // FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else if (w_start) begin
      r_state <= ST_RUN;
    end else if (w_abort || w_end) begin
      r_state <= ST_IDLE;
    end
  end

  // Config latch: only accepted while idle, so values hold during a run.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div_q   <= '0;
      r_burst_q <= '0;
    end else if (w_cfg_hs) begin
      r_div_q   <= cfg_div_i;
      r_burst_q <= cfg_burst_i;
    end
  end

  // Pulse counter and done strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pulse_cnt <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_end;
      if (w_start || w_abort || w_end) begin
        r_pulse_cnt <= '0;
      end else if (w_wrap && (r_pulse_cnt != '1)) begin
        r_pulse_cnt <= w_pulse_nxt;
      end
    end
  end

  assign cfg_ready_o = w_idle;
  assign busy_o      = w_run;
  assign done_o      = r_done;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_clk_en_sched.sv
// tb_clk_en_sched
// Directed self-checking bench for clk_en_sched. Inputs change and outputs are
// sampled 1 time unit after each rising edge. "j" below counts rising edges
// after the edge that samples start_i (edge k); an output seen at j was
// registered on edge k+j and is high during cycle k+j+1 in the block's
// numbering, e.g. DIV=3 pulses at j=4,8,12,16 are cycles 5,9,13,17.
module tb_clk_en_sched;

  localparam int CNT_W   = 6;
  localparam int BURST_W = 8;

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CNT_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               clk_en;
  logic               busy;
  logic               done;
  logic [0:0]         dbg_state;

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  clk_en_sched #(
    .CNT_W   (CNT_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_div_i   (cfg_div),
    .cfg_burst_i (cfg_burst),
    .start_i     (start),
    .stop_i      (stop),
    .clk_en_o    (clk_en),
    .busy_o      (busy),
    .done_o      (done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a config in IDLE (one accepted handshake).
  task automatic do_cfg(input int div, input int burst);
    cfg_valid = 1'b1;
    cfg_div   = CNT_W'(div);
    cfg_burst = BURST_W'(burst);
    step();
    cfg_valid = 1'b0;
  endtask

  // Sample start on the next edge (edge k).
  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    step();
    n_checks++;
    if (clk_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1 || dbg_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: clk_en=%b busy=%b done=%b ready=%b state=%b, required 0 0 0 1 0",
               clk_en, busy, done, cfg_ready, dbg_state);
    end
    rst = 1'b0;
    step();
  endtask

  // DIV=3, BURST=4: pulses at j=4,8,12,16, done with the 4th, busy falls at 16.
  task automatic test_burst();
    logic exp_en, exp_done, exp_busy;
    cfg_valid = 1'b1;
    cfg_div   = 6'd3;
    cfg_burst = 8'd4;
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_cfg_ready: got %b, required 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
    do_start();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_busy_rise: got %b, required 1", busy);
    end
    for (int j = 1; j <= 22; j++) begin
      step();
      exp_en   = (j == 4 || j == 8 || j == 12 || j == 16);
      exp_done = (j == 16);
      exp_busy = (j < 16);
      n_checks++;
      if (clk_en !== exp_en || done !== exp_done || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL burst_j%0d: clk_en=%b done=%b busy=%b, required %b %b %b",
                 j, clk_en, done, busy, exp_en, exp_done, exp_busy);
      end
    end
  endtask

  // DIV=0 continuous: pulse every edge from j=1, well past pulse counter
  // saturation (255), then stop.
  task automatic test_continuous_stop();
    int bad;
    do_cfg(0, 0);
    do_start();
    bad = 0;
    for (int j = 1; j <= 280; j++) begin
      step();
      n_checks++;
      if (clk_en !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        bad++;
        if (bad <= 5)
          $display("FAIL cont_j%0d: clk_en=%b busy=%b done=%b, required 1 1 0", j, clk_en, busy, done);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
`ifdef CLK_EN_SCHED_GRACEFUL_STOP_EN
    // Stop lands on a wrap edge: final pulse with done, then IDLE.
    n_checks++;
    if (clk_en !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_stop_edge: clk_en=%b done=%b busy=%b, required 1 1 0", clk_en, done, busy);
    end
`else
    n_checks++;
    if (clk_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_stop_edge: clk_en=%b done=%b busy=%b, required 0 0 0", clk_en, done, busy);
    end
`endif
    for (int j = 1; j <= 4; j++) begin
      step();
      n_checks++;
      if (clk_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cont_after_stop_%0d: clk_en=%b done=%b busy=%b, required 0 0 0", j, clk_en, done, busy);
      end
    end
  endtask

  // Config DIV=2/BURST=3 in the start cycle; new DIV used (pulses j=3,6,9).
  // A config offer during RUN is refused and does not alter the period.
  task automatic test_cfg_with_start();
    logic exp_en, exp_done, exp_busy;
    cfg_valid = 1'b1;
    cfg_div   = 6'd2;
    cfg_burst = 8'd3;
    start     = 1'b1;
    step();
    start     = 1'b0;
    cfg_div   = 6'd6;
    cfg_burst = 8'd1;
    for (int j = 1; j <= 12; j++) begin
      if (j <= 5) begin
        n_checks++;
        if (cfg_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL cfg_run_ready_j%0d: got %b, required 0", j, cfg_ready);
        end
      end
      if (j == 6) cfg_valid = 1'b0;
      step();
      exp_en   = (j == 3 || j == 6 || j == 9);
      exp_done = (j == 9);
      exp_busy = (j < 9);
      n_checks++;
      if (clk_en !== exp_en || done !== exp_done || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL cfg_start_j%0d: clk_en=%b done=%b busy=%b, required %b %b %b",
                 j, clk_en, done, busy, exp_en, exp_done, exp_busy);
      end
    end
  endtask

  // start and stop together in IDLE: stop wins.
  task automatic test_start_stop_idle();
    do_cfg(1, 2);
    start = 1'b1;
    stop  = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      if (j == 4) begin
        start = 1'b0;
        stop  = 1'b0;
      end
      step();
      n_checks++;
      if (clk_en !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || dbg_state !== 1'b0) begin
        n_fail++;
        $display("FAIL start_stop_idle_j%0d: clk_en=%b busy=%b ready=%b state=%b, required 0 0 1 0",
                 j, clk_en, busy, cfg_ready, dbg_state);
      end
    end
  endtask

  // Reset asynchronously while clk_en is high with DIV=5, then rerun
  // (BURST=1): single pulse with done at j=6.
  task automatic test_reset_mid_run();
    logic exp_en;
    do_cfg(5, 0);
    do_start();
    for (int j = 1; j <= 6; j++) step();
    n_checks++;
    if (clk_en !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_pulse: clk_en=%b busy=%b, required 1 1", clk_en, busy);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (clk_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_async: clk_en=%b busy=%b done=%b ready=%b, required 0 0 0 1",
               clk_en, busy, done, cfg_ready);
    end
    step();
    rst = 1'b0;
    step();
    cfg_valid = 1'b1;
    cfg_div   = 6'd5;
    cfg_burst = 8'd1;
    start     = 1'b1;
    step();
    cfg_valid = 1'b0;
    start     = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      step();
      exp_en = (j == 6);
      n_checks++;
      if (clk_en !== exp_en || done !== exp_en || busy !== (j < 6)) begin
        n_fail++;
        $display("FAIL rst_rerun_j%0d: clk_en=%b done=%b busy=%b, required %b %b %b",
                 j, clk_en, done, busy, exp_en, exp_en, (j < 6));
      end
    end
  endtask

  // DIV=7 continuous; stop sampled two edges after the pulse at j=8.
  task automatic test_graceful_stop();
    logic exp_en, exp_done, exp_busy;
    do_cfg(7, 0);
    do_start();
    for (int j = 1; j <= 24; j++) begin
      stop = (j == 10);
      step();
`ifdef CLK_EN_SCHED_GRACEFUL_STOP_EN
      exp_en   = (j == 8 || j == 16);
      exp_done = (j == 16);
      exp_busy = (j < 16);
`else
      exp_en   = (j == 8);
      exp_done = 1'b0;
      exp_busy = (j < 10);
`endif
      n_checks++;
      if (clk_en !== exp_en || done !== exp_done || busy !== exp_busy) begin
        n_fail++;
        $display("FAIL stop_div7_j%0d: clk_en=%b done=%b busy=%b, required %b %b %b",
                 j, clk_en, done, busy, exp_en, exp_done, exp_busy);
      end
    end
    stop = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cfg_valid = 1'b0;
    cfg_div   = '0;
    cfg_burst = '0;
    start     = 1'b0;
    stop      = 1'b0;
    #1;
    test_reset();
    test_burst();
    test_continuous_stop();
    test_cfg_with_start();
    test_start_stop_idle();
    test_reset_mid_run();
    test_graceful_stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
